// File: rtl/vend_arbiter.sv
// Two-panel vending arbiter: per-panel credit, round-robin grant of one shared dispenser.
// Optional dispenser-ready timeout is enabled with `define VEND_TIMEOUT_EN.
module vend_arbiter #(
    parameter int unsigned MAX_CREDIT  = 5,
    parameter int unsigned PRICE_P1    = 5,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic [1:0] sel,
    input  logic [1:0] prod,
    input  logic       disp_ready,
    output logic       disp_valid,
    output logic       disp_item,
    output logic       disp_panel,
    output logic [2:0] credit0,
    output logic [2:0] credit1,
    output logic [1:0] done,
    output logic [1:0] deny,
    output logic [1:0] coin_rej,
    output logic [1:0] fault
);

    localparam int unsigned CW = 3;
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0] MAX_S = SW'(MAX_CREDIT);
    localparam logic [SW-1:0] P0_S  = SW'(1);
    localparam logic [SW-1:0] P1_S  = SW'(PRICE_P1);

    if (TIMEOUT_CYC == 0 || PRICE_P1 > MAX_CREDIT || MAX_CREDIT > 7) begin : g_param_check
        $error("vend_arbiter: illegal parameter combination");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0][CW-1:0]    credit_q, credit_d;
    logic [1:0]            pending_q, pending_d;
    logic [1:0]            prod_q, prod_d;
    logic                  last_q, last_d;
    logic                  disp_valid_q, disp_valid_d;
    logic                  disp_item_q, disp_item_d;
    logic                  disp_panel_q, disp_panel_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            deny_q, deny_d;
    logic [1:0]            coin_rej_q, coin_rej_d;

    logic                  xfer_c;
    logic                  timeout_c;
    logic                  release_c;
    logic                  grant_c;
    logic [1:0][SW-1:0]    sum_c;
    logic [1:0][SW-1:0]    sel_price_c;

    function automatic logic [SW-1:0] price_of(input logic p);
        return p ? P1_S : P0_S;
    endfunction

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0]         cnt_q, cnt_d;
    logic [1:0]            fault_q, fault_d;

    // Cycles spent presenting without a transfer; expires after TIMEOUT_CYC cycles.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
        if (state_q == PRESENT && !xfer_c) begin
            if (cnt_q == T_LAST) begin
                timeout_c = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            fault_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        fault_d = '0;
        if (timeout_c) fault_d[disp_panel_q] = 1'b1;
    end

    assign fault = fault_q;
`else
    assign timeout_c = 1'b0;
    assign fault     = 2'b00;
`endif

    assign xfer_c    = (state_q == PRESENT) && disp_valid_q && disp_ready;
    assign release_c = xfer_c || timeout_c;

    // Credit, request and dispenser control.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        pending_d    = pending_q;
        prod_d       = prod_q;
        last_d       = last_q;
        disp_valid_d = disp_valid_q;
        disp_item_d  = disp_item_q;
        disp_panel_d = disp_panel_q;
        done_d       = '0;
        deny_d       = '0;
        coin_rej_d   = '0;
        grant_c      = 1'b0;
        sum_c        = '0;
        sel_price_c  = '0;

        for (int i = 0; i < 2; i++) begin
            // Coin and deduction on the same edge combine into one net update.
            sum_c[i] = SW'(credit_q[i]) + SW'(coin[i]);
            if (xfer_c && disp_panel_q == 1'(i)) begin
                sum_c[i] = sum_c[i] - price_of(prod_q[i]);
            end
            if (sum_c[i] > MAX_S) begin
                credit_d[i]   = CW'(MAX_S);
                coin_rej_d[i] = 1'b1;
            end else begin
                credit_d[i] = CW'(sum_c[i]);
            end

            sel_price_c[i] = price_of(prod[i]);
            if (sel[i] && !pending_q[i]) begin
                if (SW'(credit_q[i]) >= sel_price_c[i]) begin
                    pending_d[i] = 1'b1;
                    prod_d[i]    = prod[i];
                end else begin
                    deny_d[i] = 1'b1;
                end
            end

            if (release_c && disp_panel_q == 1'(i)) begin
                pending_d[i] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_c      = (pending_q == 2'b11) ? ~last_q : pending_q[1];
                    disp_valid_d = 1'b1;
                    disp_panel_d = grant_c;
                    disp_item_d  = prod_q[grant_c];
                    state_d      = PRESENT;
                end
            end
            PRESENT: begin
                if (release_c) begin
                    disp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
                if (xfer_c) begin
                    last_d               = disp_panel_q;
                    done_d[disp_panel_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            pending_q    <= '0;
            prod_q       <= '0;
            last_q       <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_item_q  <= 1'b0;
            disp_panel_q <= 1'b0;
            done_q       <= '0;
            deny_q       <= '0;
            coin_rej_q   <= '0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            pending_q    <= pending_d;
            prod_q       <= prod_d;
            last_q       <= last_d;
            disp_valid_q <= disp_valid_d;
            disp_item_q  <= disp_item_d;
            disp_panel_q <= disp_panel_d;
            done_q       <= done_d;
            deny_q       <= deny_d;
            coin_rej_q   <= coin_rej_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_item  = disp_item_q;
    assign disp_panel = disp_panel_q;
    assign credit0    = credit_q[0];
    assign credit1    = credit_q[1];
    assign done       = done_q;
    assign deny       = deny_q;
    assign coin_rej   = coin_rej_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed, table-driven bench for vend_arbiter with hand-written reset and timeout sequences.
`timescale 1ns/1ps
module tb_vend_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] coin, sel, prod;
    logic       disp_ready;
    logic       disp_valid, disp_item, disp_panel;
    logic [2:0] credit0, credit1;
    logic [1:0] done, deny, coin_rej, fault;

    int errors = 0;
    int checks = 0;

    vend_arbiter dut (
        .clk(clk), .reset(reset), .coin(coin), .sel(sel), .prod(prod),
        .disp_ready(disp_ready), .disp_valid(disp_valid), .disp_item(disp_item),
        .disp_panel(disp_panel), .credit0(credit0), .credit1(credit1),
        .done(done), .deny(deny), .coin_rej(coin_rej), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] coin, sel, prod;
        logic       rdy;
        logic       v, item, panel;
        logic [2:0] c0, c1;
        logic [1:0] done, deny, rej;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [1:0] cn, logic [1:0] sl, logic [1:0] pd, logic rdy,
                                logic v, logic item, logic panel, logic [2:0] c0, logic [2:0] c1,
                                logic [1:0] dn, logic [1:0] dy, logic [1:0] rj);
        vec_t r;
        r.rst = rst; r.coin = cn; r.sel = sl; r.prod = pd; r.rdy = rdy;
        r.v = v; r.item = item; r.panel = panel; r.c0 = c0; r.c1 = c1;
        r.done = dn; r.deny = dy; r.rej = rj;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        coin = 2'b00; sel = 2'b00; prod = 2'b00; disp_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int bad;
        logic seen;
        reset = 1'b1;
        idle_inputs();

        //        rst coin  sel   prod  rdy  v item pan c0 c1 done  deny  rej
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2, 2, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 3, 3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 4, 4, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 5, 5, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 5, 5, 2'b00, 2'b00, 2'b11));
        tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 1, 0, 0, 0, 5, 5, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 5, 5, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b00, 1, 0, 0, 0, 5, 5, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 1, 1, 0, 1, 5, 5, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 5, 4, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b10, 2'b00, 1, 1, 0, 0, 5, 4, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 4, 4, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 1, 4, 4, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 4, 3, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 1, 4, 3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 4, 3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 4, 3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 3, 3, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 3, 3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 3, 2, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 3, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 5, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 5, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 0, 5, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 0, 0, 1, 1, 0, 0, 2'b00, 2'b01, 2'b00));

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                reset = 1'b1;
                idle_inputs();
            end else begin
                coin = tbl[i].coin; sel = tbl[i].sel; prod = tbl[i].prod; disp_ready = tbl[i].rdy;
            end
            tick();
            check("disp_valid", i, 32'(disp_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                check("disp_item", i, 32'(disp_item), 32'(tbl[i].item));
                check("disp_panel", i, 32'(disp_panel), 32'(tbl[i].panel));
            end
            check("credit0", i, 32'(credit0), 32'(tbl[i].c0));
            check("credit1", i, 32'(credit1), 32'(tbl[i].c1));
            check("done", i, 32'(done), 32'(tbl[i].done));
            check("deny", i, 32'(deny), 32'(tbl[i].deny));
            check("coin_rej", i, 32'(coin_rej), 32'(tbl[i].rej));
            check("fault", i, 32'(fault), 32'(0));
            if (tbl[i].rst) reset = 1'b0;
        end

        // Reset asserted while presenting: everything drops at once.
        idle_inputs(); coin = 2'b01; tick();
        idle_inputs(); sel = 2'b01; tick();
        idle_inputs(); tick();
        check("mid_present_valid", 100, 32'(disp_valid), 32'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_valid", 101, 32'(disp_valid), 32'(0));
        check("rst_credit0", 101, 32'(credit0), 32'(0));
        check("rst_done", 101, 32'(done), 32'(0));
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_valid", 102, 32'(disp_valid), 32'(0));
        check("post_rst_done", 102, 32'(done), 32'(0));

        // Dispenser never ready: timeout behaviour depends on the build.
        idle_inputs(); coin = 2'b10; tick();
        idle_inputs(); sel = 2'b10; tick();
        idle_inputs();
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            if (disp_valid) seen = 1'b1;
        end
        check("valid_rise", 110, 32'(seen), 32'(1));
`ifdef VEND_TIMEOUT_EN
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            tick();
            k++;
            if (fault != 2'b00) seen = 1'b1;
        end
        check("fault_latency", 111, 32'(k), 32'(15));
        check("fault_panel", 111, 32'(fault), 32'(2'b10));
        check("fault_valid", 111, 32'(disp_valid), 32'(0));
        check("fault_credit1", 111, 32'(credit1), 32'(1));
        tick();
        check("fault_pulse_end", 112, 32'(fault), 32'(0));
        check("fault_idle_valid", 112, 32'(disp_valid), 32'(0));
        check("fault_no_done", 112, 32'(done), 32'(0));
`else
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (disp_valid !== 1'b1 || fault !== 2'b00 || disp_panel !== 1'b1) bad++;
        end
        check("hold_forever", 111, 32'(bad), 32'(0));
        check("hold_credit1", 111, 32'(credit1), 32'(1));
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("late_xfer_done", 112, 32'(done), 32'(2'b10));
        check("late_xfer_credit1", 112, 32'(credit1), 32'(0));
        check("late_xfer_valid", 112, 32'(disp_valid), 32'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001 Parameter MAX_CREDIT, default 5, is the per-panel credit ceiling in Q1.00 units.
REQ-002 Parameter PRICE_P1, default 5, is the price of product P1; product P0 price is fixed at 1.
REQ-003 Parameter TIMEOUT_CYC, default 15, is the dispenser-ready timeout in cycles (used only with VEND_TIMEOUT_EN).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 coin  input  2  per-panel coin pulse, bit i = panel i, +1 credit per cycle high.
REQ-007 sel  input  2  per-panel select pulse.
REQ-008 prod  input  2  per-panel product id sampled with sel: 0 = P0, 1 = P1.
REQ-009 disp_ready  input  1  shared dispenser accepts the presented item.
REQ-010 disp_valid  output  1  item presented to the dispenser.
REQ-011 disp_item  output  1  product id presented.
REQ-012 disp_panel  output  1  panel owning the presented item.
REQ-013 credit0, credit1  output  3 each  registered credit of panel 0 / panel 1.
REQ-014 done, deny, coin_rej, fault  output  2 each  one-cycle per-panel status pulses.

Function
REQ-015 Each panel keeps an independent credit register, range 0..MAX_CREDIT.
REQ-016 coin[i] high at an edge increments credit i by 1; at MAX_CREDIT the credit holds and coin_rej[i] pulses the next cycle.
REQ-017 sel[i] with no pending request for panel i and credit i >= price(prod[i]): set pending[i] and latch prod[i] at that edge.
REQ-018 sel[i] with insufficient credit: no pending set, deny[i] pulses the next cycle.
REQ-019 sel[i] while pending[i] is set is ignored, with no pulse.
REQ-020 FSM states: IDLE, PRESENT; reset enters IDLE.
REQ-021 IDLE with any pending: choose a panel, register disp_valid=1 with disp_item/disp_panel, go to PRESENT; disp_valid therefore rises one cycle after pending sets.
REQ-022 Arbitration is round-robin: with both pending, grant the panel not served last; a last-served pointer resets to 1 so that panel 0 wins first.
REQ-023 PRESENT holds disp_valid, disp_item and disp_panel stable until the transfer edge (disp_valid && disp_ready).
REQ-024 At the transfer edge: deduct the price from the granted panel's credit, clear its pending, update last-served, return to IDLE, and pulse done[panel] the next cycle.
REQ-025 disp_valid is low for at least one cycle between consecutive grants.
REQ-026 A coin and a deduction on the same panel at the same edge apply a net credit + 1 - price, saturated at MAX_CREDIT; coin_rej pulses only if the net value would exceed MAX_CREDIT.
REQ-027 Coins to either panel are accepted in every state.
REQ-028 Credit never underflows; credit remains >= price while pending, because deduction occurs only at transfer.

Reset
REQ-029 Reset clears all of the following: credits to 0, pending to 0, FSM to IDLE, last-served to 1, and all outputs to 0, including disp_valid and every pulse output.
REQ-030 Reset asserted mid-PRESENT drops disp_valid immediately, with no deduction and no done pulse.

Configuration
REQ-031 Macro VEND_TIMEOUT_EN defined: a cycle counter runs in PRESENT; if no transfer occurs within TIMEOUT_CYC cycles of disp_valid rising, the block drops disp_valid, clears that pending, makes no deduction, pulses fault[panel], and returns to IDLE.
REQ-032 VEND_TIMEOUT_EN undefined: PRESENT waits indefinitely, no counter logic exists, and fault is tied to 0.

Verification
REQ-033 Reset; panel 0 receives 1 coin, then sel with prod=0, disp_ready=1 -> disp_valid rises 1 cycle after pending sets, credit0 1->0, done[0] pulses once.
REQ-034 Panel 1 with credit 3 receives sel with prod=1 -> deny[1] pulses, credit1 stays 3, disp_valid stays 0.
REQ-035 Both panels hold credit 5 and are pending with P0, disp_ready=1 -> grants go panel 0 then panel 1, and a second round begins again with panel 0.
REQ-036 Credit 5 plus coin -> coin_rej pulses, credit stays 5; credit 5 with P0 transfer and coin at the same edge -> credit 5, no coin_rej.
REQ-037 Assert reset during PRESENT with disp_ready=0 -> disp_valid=0, credit=0, done=0.
REQ-038 With VEND_TIMEOUT_EN and disp_ready held at 0 -> fault pulses 15 cycles after disp_valid rises, credit is unchanged, and the FSM returns to IDLE.
